planar_drain_sequencer: RTL

PLANAR_DRAIN_SEQUENCER -- requirements
Module: planar_drain_sequencer

---
 rtl/planar_drain_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/planar_drain_sequencer.sv
// planar_drain_sequencer: opens the chain of flow switches from the outlet
// (position 0) up to the switch serving the selected chamber, holds the
// drain path open, then closes it back down to the outlet.
//
// Optional feature macro: ROUTE_ABORT_EN adds an abort input. When abort is
// high in OPEN or DWELL, the path closes early from the highest set bit.
//
// Timing, counted from the acceptance edge (edge 0):
//   bit j of sw_en is set at edge j*SETTLE_CYC,
//   DWELL starts at edge (p+1)*SETTLE_CYC,
//   bit p is cleared at edge (p+1)*SETTLE_CYC + DWELL_CYC,
//   DONE is entered at edge 2*(p+1)*SETTLE_CYC + DWELL_CYC.
// done is high during the cycle after that edge. The acceptance-to-done latency
// is therefore 2*(p+1)*SETTLE_CYC + DWELL_CYC cycles. This is one cycle below
// the nominal formula because bit 0 is set on the acceptance edge itself.
module planar_drain_sequencer #(
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_pos,
  input  logic        req_side,
  output logic [11:0] sw_en,
  output logic        term_sel,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef ROUTE_ABORT_EN
  ,
  input  logic        abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_DWELL = 3'd2,
    S_CLOSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DWELL_LD  = 16'(DWELL_CYC - 1);

  // Positions 0 (outlet) and 6 (source switch) cannot serve a chamber.
  function automatic logic pos_valid(input logic [3:0] p);
    return ((p >= 4'd1) && (p <= 4'd5)) || ((p >= 4'd7) && (p <= 4'd11));
  endfunction

  state_t      state_q, state_d;
  logic [11:0] sw_en_q, sw_en_d;
  logic        term_sel_q, term_sel_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        abort_s;

`ifdef ROUTE_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and next-output computation for the drain sequence.
  always_comb begin
    state_d    = state_q;
    sw_en_d    = sw_en_q;
    term_sel_d = term_sel_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    cnt_d      = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : 16'd0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          if (pos_valid(req_pos)) begin
            state_d    = S_OPEN;
            term_sel_d = req_side;
            pos_d      = req_pos;
            idx_d      = 4'd0;
            sw_en_d    = 12'h001;
            cnt_d      = SETTLE_LD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OPEN, S_DWELL: begin
        if (abort_s) begin
          // Close early, starting from the highest bit that is currently set.
          state_d = S_CLOSE;
          sw_en_d = sw_en_q & ~(12'd1 << idx_q);
          cnt_d   = SETTLE_LD;
        end else if (cnt_q != 16'd0) begin
          state_d = state_q;
        end else if (state_q == S_DWELL) begin
          state_d = S_CLOSE;
          sw_en_d = sw_en_q & ~(12'd1 << idx_q);
          cnt_d   = SETTLE_LD;
        end else if (idx_q == pos_q) begin
          state_d = S_DWELL;
          cnt_d   = DWELL_LD;
        end else begin
          idx_d   = idx_q + 4'd1;
          sw_en_d = sw_en_q | (12'd1 << (idx_q + 4'd1));
          cnt_d   = SETTLE_LD;
        end
      end
      S_CLOSE: begin
        if (cnt_q != 16'd0) begin
          state_d = S_CLOSE;
        end else if (idx_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 4'd1;
          sw_en_d = sw_en_q & ~(12'd1 << (idx_q - 4'd1));
          cnt_d   = SETTLE_LD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        sw_en_d = 12'h000;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, timer and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sw_en_q    <= 12'h000;
      term_sel_q <= 1'b0;
      pos_q      <= 4'd0;
      idx_q      <= 4'd0;
      cnt_q      <= 16'd0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_en_q    <= sw_en_d;
      term_sel_q <= term_sel_d;
      pos_q      <= pos_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sw_en     = sw_en_q;
  assign term_sel  = term_sel_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
